mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning columns mixed per clock; legal values 1, 2, 4.
REQ-002 SHALL have localparam NCYC = 4/COLS_PER_CYCLE, meaning compute cycles per 128-bit state.
REQ-003 iClk  input  1  sole clock, rising-edge; reset is asynchronous and active-low.
REQ-004 iRst_n  input  1  asynchronous active-low reset.
REQ-005 iValid  input  1  upstream state valid.
REQ-006 oReady  output  1  engine can accept a state this cycle.
REQ-007 iState  input  128  input state; column c = iState[127-32c -: 32], row 0 in the MSB byte.
REQ-008 iInv  input  1  1 = InvMixColumns, 0 = MixColumns.
REQ-009 iBypass  input  1  1 = pass state unchanged (final AES round).
REQ-010 oValid  output  1  result valid.
REQ-011 iReady  input  1  downstream accepts result.
REQ-012 oState  output  128  result, same column/byte layout as iState.

Function
REQ-013 SHALL accept a state when iValid && oReady, latching iState, iInv and iBypass.
REQ-014 SHALL ignore iInv, iBypass and iState changes after acceptance until the next acceptance.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 IDLE -> BUSY on accept; column counter cleared to 0.
REQ-017 BUSY SHALL process COLS_PER_CYCLE columns per cycle, lowest column index first, counter += COLS_PER_CYCLE.
REQ-018 BUSY -> DONE after exactly NCYC cycles; a state accepted at edge T SHALL give oValid=1 from edge T+NCYC.
REQ-019 Forward mix per column SHALL use matrix rows {02 03 01 01} rotated, GF(2^8) polynomial 0x11B.
REQ-020 Inverse mix SHALL use rows {0E 0B 0D 09} rotated, same polynomial.
REQ-021 Bypass SHALL traverse BUSY with identical NCYC latency and output the latched state unmodified.
REQ-022 oReady SHALL be 1 in IDLE, 1 in DONE when iReady=1, else 0.
REQ-023 DONE with iReady=1 and no accept SHALL go to IDLE, oValid falling next cycle.
REQ-024 DONE with iReady=1 and simultaneous accept SHALL go straight to BUSY, with no bubble beyond NCYC.
REQ-025 DONE with iReady=0: oValid and oState SHALL hold stable indefinitely.
REQ-026 oState SHALL change only when entering DONE and SHALL be valid whenever oValid=1.
REQ-027 Column counter arithmetic SHALL be 2 bits, wrapping to 0 on BUSY exit.

Reset
REQ-028 iRst_n low SHALL immediately force IDLE, oValid=0, oReady=0 while asserted, oState=128'h0, counter=0.
REQ-029 After deassertion oReady SHALL be 1 on the first cycle in IDLE.
REQ-030 Reset mid-BUSY or mid-DONE SHALL discard the in-flight state with no partial output.

Structure
REQ-031 Shared package aes_pkg SHALL hold the polynomial constant 8'h1B, the forward/inverse coefficient constants and the FSM state encoding.
REQ-032 SHALL instantiate COLS_PER_CYCLE copies of sub-module gf_col_mix: combinational 32-bit column mixer with iInv select, using xtime chains (x2, x4, x8).
REQ-033 All sequencing and storage SHALL be in mix_columns_engine; gf_col_mix SHALL be stateless.

Verification
REQ-034 Forward, each column = db135345 / f20a225c / 01010101 / c6c6c6c6 -> 8e4da1bc / 9fdc589d / 01010101 / c6c6c6c6, oValid at T+NCYC, for COLS_PER_CYCLE 1, 2, 4.
REQ-035 Inverse on 8e4da1bc9fdc589d01010101c6c6c6c6 -> db135345f20a225c01010101c6c6c6c6; forward column d4d4d4d5 -> d5d5d7d6, 2d26314c -> 4d7ebdf8.
REQ-036 Bypass with iState=00112233445566778899aabbccddeeff -> identical oState, same latency as non-bypass.
REQ-037 Back-to-back: iValid held high with iReady=1 for 3 states -> one result every NCYC cycles, no extra bubbles; then iReady=0 for 5 cycles -> oState stable, oReady=0.
REQ-038 Assert iRst_n low two cycles into BUSY (COLS_PER_CYCLE=1) -> oValid stays 0, oState=0, next accepted state produces a correct result.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: GF(2^8) constants, MixColumns coefficient rows, engine FSM encoding and xtime-chain multiply helpers
package aes_pkg;
  localparam logic [7:0] POLY = 8'h1B;
  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0E0B0D09;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction
  // All MixColumns coefficients fit in a nibble, so a product needs only x1/x2/x4/x8
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction
endpackage

// File: rtl/gf_col_mix.sv
// gf_col_mix: stateless 32-bit column mixer (MixColumns or InvMixColumns)
//   iCol : input column, row 0 in the MSB byte
//   iInv : 1 selects the inverse matrix
//   oCol : mixed column, same byte layout
module gf_col_mix
  import aes_pkg::*;
(
  input  logic [31:0] iCol,
  input  logic        iInv,
  output logic [31:0] oCol
);
  logic [31:0] m;
  assign m = iInv ? INV_COEF : FWD_COEF;
  // Output row i uses the coefficient row rotated right by i: out_i = sum_j M[(j-i) mod 4] * a_j
  always_comb begin
    oCol = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        oCol[31-8*i -: 8] = oCol[31-8*i -: 8] ^ gmul(iCol[31-8*j -: 8], m[27-8*((j-i)&3) -: 4]);
  end
endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: iterative AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock
//   iClk/iRst_n       : clock, async active-low reset
//   iValid/oReady     : input handshake; iState/iInv/iBypass latched on accept
//   oValid/iReady     : output handshake; oState held while oValid && !iReady
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iValid,
  output logic         oReady,
  input  logic [127:0] iState,
  input  logic         iInv,
  input  logic         iBypass,
  output logic         oValid,
  input  logic         iReady,
  output logic [127:0] oState
);
  localparam int NCYC = 4 / COLS_PER_CYCLE;
  state_t state, nxt_state;
  logic [1:0] cnt;
  logic [127:0] st, res, res_nxt;
  logic inv, byp, accept, last;
  logic [1:0] idx [COLS_PER_CYCLE];
  logic [31:0] col_in [COLS_PER_CYCLE];
  logic [31:0] col_mix [COLS_PER_CYCLE];
  assign oValid = state == DONE;
  assign oReady = iRst_n && (state == IDLE || (state == DONE && iReady));
  assign accept = iValid && oReady;
  // 2-bit counter: the final BUSY cycle is the one whose increment wraps to 0
  assign last = cnt == 2'(4 - COLS_PER_CYCLE);
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign idx[g] = cnt + 2'(g);
    assign col_in[g] = st[127-32*int'(idx[g]) -: 32];
    gf_col_mix u_mix (.iCol(col_in[g]), .iInv(inv), .oCol(col_mix[g]));
  end
  always_comb begin
    res_nxt = res;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      res_nxt[127-32*int'(idx[k]) -: 32] = byp ? col_in[k] : col_mix[k];
  end
  always_comb begin
    nxt_state = state;
    nxt_state = state == IDLE ? (accept ? BUSY : IDLE)
              : state == BUSY ? (last ? DONE : BUSY)
              : iReady ? (iValid ? BUSY : IDLE) : DONE;
  end
  // res accumulates partial columns so oState only changes on entering DONE
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt <= '0;
      st <= '0;
      res <= '0;
      oState <= '0;
      inv <= 1'b0;
      byp <= 1'b0;
    end else begin
      state <= nxt_state;
      if (accept) begin
        st <= iState;
        inv <= iInv;
        byp <= iBypass;
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 2'(COLS_PER_CYCLE);
        res <= res_nxt;
        if (last) oState <= res_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: directed self-checking bench for three engine widths (1, 2, 4 columns per cycle)
module tb_mix_columns_engine;
  localparam logic [127:0] FWD_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] ALT_IN  = 128'hd4d4d4d52d26314c01010101c6c6c6c6;
  localparam logic [127:0] ALT_OUT = 128'hd5d5d7d64d7ebdf801010101c6c6c6c6;
  localparam logic [127:0] BYP_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ONES    = 128'h01010101010101010101010101010101;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] vin = '0;
  logic [2:0] rdy, ov;
  logic [127:0] ost [3];
  logic [127:0] st_in = '0;
  logic inv = 1'b0, byp = 1'b0, rin = 1'b0;
  int checks = 0, failures = 0;
  logic [127:0] seq_in [3];
  logic [127:0] seq_out [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) dut (
      .iClk(clk), .iRst_n(rst_n), .iValid(vin[g]), .oReady(rdy[g]),
      .iState(st_in), .iInv(inv), .iBypass(byp), .oValid(ov[g]),
      .iReady(rin), .oState(ost[g])
    );
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input int d, output int n);
    n = 0;
    while (!ov[d] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic xfer(input int d, input logic [127:0] s, input logic i, input logic b,
                      input logic [127:0] exp, input string tag);
    int n;
    @(negedge clk);
    vin[d] = 1'b1;
    st_in = s;
    inv = i;
    byp = b;
    rin = 1'b0;
    #1 chk({tag, "_ready"}, 128'(rdy[d]), 128'd1);
    @(posedge clk);
    #1;
    vin[d] = 1'b0;
    st_in = ~s;
    inv = ~i;
    byp = ~b;
    wait_valid(d, n);
    chk({tag, "_latency"}, 128'(n), 128'(4 >> d));
    chk({tag, "_state"}, ost[d], exp);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold_valid"}, 128'(ov[d]), 128'd1);
    chk({tag, "_hold_state"}, ost[d], exp);
    @(negedge clk);
    rin = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_drain"}, 128'(ov[d]), 128'd0);
    rin = 1'b0;
  endtask
  initial begin
    int n;
    seq_in[0] = FWD_IN;
    seq_in[1] = ALT_IN;
    seq_in[2] = ONES;
    seq_out[0] = FWD_OUT;
    seq_out[1] = ALT_OUT;
    seq_out[2] = ONES;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid%0d", d), 128'(ov[d]), 128'd0);
      chk($sformatf("rst_ready%0d", d), 128'(rdy[d]), 128'd0);
      chk($sformatf("rst_state%0d", d), ost[d], 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("post_rst_ready%0d", d), 128'(rdy[d]), 128'd1);
    xfer(0, FWD_IN, 1'b0, 1'b0, FWD_OUT, "fwd_c1");
    xfer(1, FWD_IN, 1'b0, 1'b0, FWD_OUT, "fwd_c2");
    xfer(2, FWD_IN, 1'b0, 1'b0, FWD_OUT, "fwd_c4");
    xfer(0, FWD_OUT, 1'b1, 1'b0, FWD_IN, "inv_c1");
    xfer(2, FWD_OUT, 1'b1, 1'b0, FWD_IN, "inv_c4");
    xfer(1, ALT_IN, 1'b0, 1'b0, ALT_OUT, "alt_c2");
    xfer(0, BYP_IN, 1'b0, 1'b1, BYP_IN, "byp_c1");
    xfer(2, BYP_IN, 1'b1, 1'b1, BYP_IN, "byp_c4");
    // back-to-back stream on the single-column engine
    @(negedge clk);
    vin[0] = 1'b1;
    rin = 1'b1;
    inv = 1'b0;
    byp = 1'b0;
    st_in = seq_in[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      st_in = '0;
      wait_valid(0, n);
      chk($sformatf("b2b_latency%0d", i), 128'(n), 128'd4);
      chk($sformatf("b2b_state%0d", i), ost[0], seq_out[i]);
      if (i < 2) st_in = seq_in[i+1];
    end
    rin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("stall_ready%0d", i), 128'(rdy[0]), 128'd0);
      chk($sformatf("stall_valid%0d", i), 128'(ov[0]), 128'd1);
      chk($sformatf("stall_state%0d", i), ost[0], ONES);
      @(posedge clk);
    end
    #1;
    vin[0] = 1'b0;
    rin = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_drain", 128'(ov[0]), 128'd0);
    rin = 1'b0;
    // reset two cycles into BUSY discards the in-flight state
    @(negedge clk);
    vin[0] = 1'b1;
    st_in = ALT_IN;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_no_partial", ost[0], ONES);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(ov[0]), 128'd0);
    chk("midrst_ready", 128'(rdy[0]), 128'd0);
    chk("midrst_state", ost[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_idle_valid", 128'(ov[0]), 128'd0);
    chk("postrst_idle_state", ost[0], 128'd0);
    xfer(0, FWD_IN, 1'b0, 1'b0, FWD_OUT, "postrst_fwd");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
